// File: rtl/shift_add_multiplier.sv
// Radix-2 shift-add multiplier, signed or unsigned; product valid exactly WIDTH cycles after accept.
// Result held on p/out_valid until out_ready; in_ready only while idle, operands ignored otherwise.
module shift_add_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               signed_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p,
   output logic               busy
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t             state, state_nxt;
   logic [2*WIDTH-1:0] acc, mcand, acc_sum;
   logic [WIDTH-1:0]   mplier, a_mag, b_mag;
   logic [CW-1:0]      cnt;
   logic               sign;
   logic               last;

   // Magnitudes stay unsigned WIDTH bits, so the most-negative operand maps to 2^(WIDTH-1) exactly.
   assign a_mag   = (signed_mode && a[WIDTH-1]) ? -a : a;
   assign b_mag   = (signed_mode && b[WIDTH-1]) ? -b : b;
   assign acc_sum = acc + (mplier[0] ? mcand : '0);
   assign last    = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_nxt = CALC;
         end
         CALC: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         sign   <= 1'b0;
         p      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  acc    <= '0;
                  mcand  <= {{WIDTH{1'b0}}, a_mag};
                  mplier <= b_mag;
                  cnt    <= '0;
                  sign   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
               end
            end
            CALC: begin
               acc    <= acc_sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               // Final partial product is folded in here so DONE needs no extra cycle.
               if (last) p <= sign ? -acc_sum : acc_sum;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Checks WIDTH=4, 8 and 16 instances against an arithmetic reference, fixed vectors and handshake corner cases.
module tb_shift_add_multiplier;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, iv, ordy, sm;
   logic [31:0] a_d, b_d;
   int          sel;

   logic        ir4, ov4, bz4, ir8, ov8, bz8, ir16, ov16, bz16;
   logic [7:0]  p4;
   logic [15:0] p8;
   logic [31:0] p16;
   logic        iv4, iv8, iv16;

   logic        cur_ir, cur_ov, cur_bz;
   logic [63:0] cur_p;

   int n_tests = 0;
   int n_fail  = 0;

   assign iv4  = iv && (sel == 0);
   assign iv8  = iv && (sel == 1);
   assign iv16 = iv && (sel == 2);

   shift_add_multiplier #(.WIDTH(4)) u4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a_d[3:0]), .b(b_d[3:0]),
      .signed_mode(sm), .out_valid(ov4), .out_ready(ordy), .p(p4), .busy(bz4));

   shift_add_multiplier #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a_d[7:0]), .b(b_d[7:0]),
      .signed_mode(sm), .out_valid(ov8), .out_ready(ordy), .p(p8), .busy(bz8));

   shift_add_multiplier #(.WIDTH(16)) u16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a_d[15:0]), .b(b_d[15:0]),
      .signed_mode(sm), .out_valid(ov16), .out_ready(ordy), .p(p16), .busy(bz16));

   always_comb begin
      cur_ir = ir16; cur_ov = ov16; cur_bz = bz16; cur_p = {32'b0, p16};
      case (sel)
         0: begin cur_ir = ir4; cur_ov = ov4; cur_bz = bz4; cur_p = {56'b0, p4}; end
         1: begin cur_ir = ir8; cur_ov = ov8; cur_bz = bz8; cur_p = {48'b0, p8}; end
         default: ;
      endcase
   end

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic        m;
      logic [15:0] exp;
   } vec_t;

   vec_t vt[8];

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Signed/unsigned product of w-bit operands, truncated to 2w bits, by plain integer arithmetic.
   function automatic logic [63:0] ref_mul(input int w, input logic [31:0] av, input logic [31:0] bv,
                                           input logic m);
      longint x, y, mask;
      mask = (longint'(1) << w) - 1;
      x = longint'(av) & mask;
      y = longint'(bv) & mask;
      if (m && x[w-1]) x = x - (longint'(1) << w);
      if (m && y[w-1]) y = y - (longint'(1) << w);
      return 64'(x * y) & ((64'd1 << (2 * w)) - 64'd1);
   endfunction

   // Called at a negedge; returns at the negedge where out_valid is seen (edges counted from accept).
   task automatic wait_ov(output int n);
      n = 0;
      while (!cur_ov && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic do_op(input int k, input logic [31:0] av, input logic [31:0] bv, input logic m,
                        output logic [63:0] pr, output int lat);
      @(negedge clk);
      sel = k; a_d = av; b_d = bv; sm = m; iv = 1'b1; ordy = 1'b1;
      @(negedge clk);
      iv = 1'b0;
      wait_ov(lat);
      pr = cur_p;
   endtask

   initial begin
      logic [63:0] pr;
      int          lat;
      int          seen;
      logic [31:0] av, bv;
      logic        m;

      vt[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
      vt[1] = '{8'hFD, 8'h05, 1'b1, 16'hFFF1};
      vt[2] = '{8'h80, 8'h80, 1'b1, 16'h4000};
      vt[3] = '{8'h00, 8'h7F, 1'b1, 16'h0000};
      vt[4] = '{8'h12, 8'h00, 1'b0, 16'h0000};
      vt[5] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
      vt[6] = '{8'h7F, 8'h80, 1'b1, 16'hC080};
      vt[7] = '{8'h80, 8'h01, 1'b0, 16'h0080};

      rst = 1'b1; iv = 1'b0; ordy = 1'b1; sm = 1'b0; a_d = '0; b_d = '0; sel = 0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         sel = k;
         #1;
         chk("reset in_ready", {63'b0, cur_ir}, 64'd1);
         chk("reset out_valid", {63'b0, cur_ov}, 64'd0);
         chk("reset busy", {63'b0, cur_bz}, 64'd0);
         chk("reset p", cur_p, 64'd0);
      end
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         do_op(1, {24'b0, vt[i].a}, {24'b0, vt[i].b}, vt[i].m, pr, lat);
         chk($sformatf("w8 vec%0d p", i), pr, {48'b0, vt[i].exp});
         chk($sformatf("w8 vec%0d latency", i), 64'(lat), 64'd8);
      end

      for (int mi = 0; mi < 2; mi++) begin
         for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
               av = 32'(x); bv = 32'(y); m = (mi == 1);
               do_op(0, av, bv, m, pr, lat);
               chk($sformatf("w4 m%0d %0d*%0d p", mi, x, y), pr, ref_mul(4, av, bv, m));
               chk($sformatf("w4 m%0d %0d*%0d latency", mi, x, y), 64'(lat), 64'd4);
            end
         end
      end

      for (int i = 0; i < 1000; i++) begin
         av = $urandom & 32'hFFFF; bv = $urandom & 32'hFFFF; m = 1'($urandom_range(0, 1));
         do_op(2, av, bv, m, pr, lat);
         chk($sformatf("w16 rnd%0d %0h*%0h m%0d p", i, av, bv, m), pr, ref_mul(16, av, bv, m));
         chk($sformatf("w16 rnd%0d latency", i), 64'(lat), 64'd16);
      end

      // Back-to-back with in_valid held; operand changes while busy must not leak into the result.
      @(negedge clk);
      sel = 1; a_d = 32'd7; b_d = 32'd9; sm = 1'b0; iv = 1'b1; ordy = 1'b1;
      @(negedge clk);
      chk("b2b busy after accept", {63'b0, cur_bz}, 64'd1);
      a_d = 32'd3; b_d = 32'd4;
      wait_ov(lat);
      chk("b2b first latency", 64'(lat), 64'd8);
      chk("b2b first p", cur_p, 64'd63);
      @(negedge clk);
      chk("b2b idle after handshake", {63'b0, cur_ir}, 64'd1);
      @(negedge clk);
      chk("b2b second accept", {63'b0, cur_bz}, 64'd1);
      iv = 1'b0;
      wait_ov(lat);
      chk("b2b second latency", 64'(lat), 64'd8);
      chk("b2b second p", cur_p, 64'd12);

      // Backpressure: hold five cycles, then release.
      @(negedge clk);
      a_d = 32'hFD; b_d = 32'h05; sm = 1'b1; iv = 1'b1; ordy = 1'b0;
      @(negedge clk);
      iv = 1'b0;
      wait_ov(lat);
      chk("bp p", cur_p, 64'hFFF1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("bp hold%0d out_valid", i), {63'b0, cur_ov}, 64'd1);
         chk($sformatf("bp hold%0d p", i), cur_p, 64'hFFF1);
      end
      ordy = 1'b1;
      @(negedge clk);
      chk("bp idle after release", {63'b0, cur_ir}, 64'd1);
      chk("bp out_valid dropped", {63'b0, cur_ov}, 64'd0);
      chk("bp p retained", cur_p, 64'hFFF1);

      // Reset at CALC cycle 4, with in_valid also high so rst must beat the handshake.
      a_d = 32'h55; b_d = 32'h33; sm = 1'b0; iv = 1'b1;
      @(negedge clk);
      iv = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1; iv = 1'b1;
      @(negedge clk);
      chk("calc abort idle", {63'b0, cur_ir}, 64'd1);
      chk("calc abort busy", {63'b0, cur_bz}, 64'd0);
      chk("calc abort p", cur_p, 64'd0);
      rst = 1'b0; iv = 1'b0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cur_ov) seen++;
      end
      chk("calc abort no out_valid", 64'(seen), 64'd0);

      // Reset while DONE and stalled.
      a_d = 32'h0A; b_d = 32'h0B; iv = 1'b1; ordy = 1'b0;
      @(negedge clk);
      iv = 1'b0;
      wait_ov(lat);
      chk("done stall p", cur_p, 64'd110);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; ordy = 1'b1;
      chk("done abort out_valid", {63'b0, cur_ov}, 64'd0);
      chk("done abort p", cur_p, 64'd0);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (cur_ov) seen++;
      end
      chk("done abort no out_valid", 64'(seen), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operand pair and mode present.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  WIDTH  multiplicand.
REQ-007 SHALL have port b  input  WIDTH  multiplier.
REQ-008 SHALL have port signed_mode  input  1  1 = a, b and p are two's complement; 0 = unsigned.
REQ-009 SHALL have port out_valid  output  1  p holds a finished product.
REQ-010 SHALL have port out_ready  input  1  consumer takes the product.
REQ-011 SHALL have port p  output  2*WIDTH  product.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement states IDLE, CALC and DONE.
REQ-014 SHALL drive in_ready high only in IDLE, and out_valid high only in DONE.
REQ-015 SHALL accept operands on an edge where in_valid and in_ready are both high:
- capture a, b and signed_mode;
- clear the accumulator;
- clear the bit counter;
- go to CALC.
REQ-016 SHALL, in signed mode, convert each operand to its magnitude at capture and record sign = a[MSB] XOR b[MSB]; in unsigned mode sign = 0.
REQ-017 SHALL, on each CALC edge:
- add the shifted multiplicand magnitude to the accumulator if the current multiplier-magnitude bit is 1;
- shift;
- increment the counter.
REQ-018 SHALL go from CALC to DONE on the WIDTH-th CALC edge, registering p = sign ? -accumulator : accumulator, truncated to 2*WIDTH bits.
REQ-019 SHALL make out_valid first visible exactly WIDTH cycles after the accepting edge, with no data-dependent early exit.
REQ-020 SHALL hold p and out_valid stable while out_valid is high and out_ready is low.
REQ-021 SHALL return to IDLE on an edge with out_valid and out_ready both high, leaving p at its last value.
REQ-022 SHALL ignore in_valid and changes on a, b and signed_mode outside IDLE.
REQ-023 SHALL give exact results at the boundaries:
- most-negative times most-negative in signed mode; for WIDTH=8, -128*-128 = 0x4000;
- all-ones times all-ones in unsigned mode; for WIDTH=8, 0xFE01;
- any operand equal to zero gives p = 0 with the same latency.
REQ-024 SHALL, when WIDTH=4 and signed_mode=0, produce the same p as the existing 4-bit combinational array multiplier for all 256 operand pairs.

Reset
REQ-025 SHALL, on any edge with rst high:
- force IDLE;
- set in_ready = 1;
- set out_valid = 0, busy = 0, p = 0;
- clear the accumulator, counter and captured operands.
REQ-026 SHALL let rst take priority over every other event, including a simultaneous handshake.
REQ-027 SHALL make any operation aborted by rst in CALC or DONE produce no out_valid pulse.

Verification
REQ-028 SHALL cover, with WIDTH=8:
- unsigned 255*255 -> p = 0xFE01, out_valid exactly 8 cycles after accept;
- signed -3*5 -> p = 0xFFF1;
- signed -128*-128 -> p = 0x4000.
REQ-029 SHALL cover back-to-back operation: in_valid held high -> next accept one cycle after each out_valid/out_ready handshake; no operand accepted while busy.
REQ-030 SHALL cover backpressure: out_ready low for 5 cycles after out_valid -> p and out_valid stable throughout; IDLE the cycle after out_ready rises.
REQ-031 SHALL cover reset mid-CALC (rst at CALC cycle 4): next cycle in IDLE with p = 0, and no out_valid ever for that operation.
REQ-032 SHALL cover, for a WIDTH=4 instance, an exhaustive unsigned sweep (256 pairs) and an exhaustive signed sweep, each checked against a reference model.
REQ-033 SHALL cover, for a WIDTH=16 instance, 1000 random signed and unsigned pairs, each checked against a reference model, with fixed latency 16.
